// File: rtl/cpu_ctrl_pkg.sv
// Shared control types for the pipelined LEGv8 control unit: opcodes, ALU op
// encoding, per-stage control bundles and their bubble values.
package cpu_ctrl_pkg;

  localparam int unsigned XFER_SZ_W = 4;

  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_LDURB = 11'b00111000010;
  localparam logic [10:0] OP_STURB = 11'b00111000000;
  localparam logic [10:0] OP_BR    = 11'b11010110000;

  localparam logic [XFER_SZ_W-1:0] XFER_DWORD = 4'd8;
  localparam logic [XFER_SZ_W-1:0] XFER_BYTE  = 4'd1;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'b000,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011
  } alu_op_e;

  typedef struct packed {
    logic    alu_src;
    logic    imm_select;
    logic    flagset;
    alu_op_e alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic                 mem_write;
    logic                 mem_read;
    logic [XFER_SZ_W-1:0] xfer_size;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic blink;
  } wb_ctrl_t;

  typedef struct packed {
    logic reg2loc;
    logic uncond_br;
    logic breg;
    logic blink;
    logic uncond_taken;
    logic is_cbz;
    logic is_blt;
    logic reads_rn;
    logic reads_rm;
  } id_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } id_ex_t;

  typedef struct packed {
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ex_mem_t;

  localparam id_ctrl_t  ID_BUBBLE     = '0;
  localparam ex_ctrl_t  EX_BUBBLE     = '0;
  localparam mem_ctrl_t MEM_BUBBLE    = '0;
  localparam wb_ctrl_t  WB_BUBBLE     = '0;
  localparam id_ex_t    ID_EX_BUBBLE  = '0;
  localparam ex_mem_t   EX_MEM_BUBBLE = '0;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Datapath-facing bundle of the control unit: ID-stage inputs, live ALU flags
// and every stage's control outputs.
interface pipelined_control_unit_if #(
  parameter int unsigned OPC_W  = 11,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned XFER_W = 4
);
  logic [OPC_W-1:0]  opcode_id;
  logic [REG_W-1:0]  rn_id;
  logic [REG_W-1:0]  rm_id;
  logic [REG_W-1:0]  rd_ex;
  logic              zero_check;
  logic              alu_n;
  logic              alu_z;
  logic              alu_v;
  logic              alu_c;

  logic              id_Reg2Loc;
  logic              id_UncondBr;
  logic              id_BrTaken;
  logic              id_breg;
  logic              id_blink;
  logic              if_flush;
  logic              hazard_stall;
  logic              ex_ALUSrc;
  logic              ex_imm_select;
  logic              ex_flagset;
  logic [2:0]        ex_ALUOp;
  logic              mem_MemWrite;
  logic              mem_MemRead;
  logic [XFER_W-1:0] mem_xfer_size;
  logic              wb_RegWrite;
  logic              wb_MemToReg;
  logic              wb_blink;
  logic [3:0]        flags_q;
  logic              illegal_op;

  modport master (
    output opcode_id, rn_id, rm_id, rd_ex, zero_check,
           alu_n, alu_z, alu_v, alu_c,
    input  id_Reg2Loc, id_UncondBr, id_BrTaken, id_breg, id_blink,
           if_flush, hazard_stall,
           ex_ALUSrc, ex_imm_select, ex_flagset, ex_ALUOp,
           mem_MemWrite, mem_MemRead, mem_xfer_size,
           wb_RegWrite, wb_MemToReg, wb_blink,
           flags_q, illegal_op
  );

  modport slave (
    input  opcode_id, rn_id, rm_id, rd_ex, zero_check,
           alu_n, alu_z, alu_v, alu_c,
    output id_Reg2Loc, id_UncondBr, id_BrTaken, id_breg, id_blink,
           if_flush, hazard_stall,
           ex_ALUSrc, ex_imm_select, ex_flagset, ex_ALUOp,
           mem_MemWrite, mem_MemRead, mem_xfer_size,
           wb_RegWrite, wb_MemToReg, wb_blink,
           flags_q, illegal_op
  );
endinterface

// File: rtl/ctrl_decoder.sv
// Pure combinational LEGv8 opcode decoder; every unmatched opcode yields an
// all-zero bubble with valid deasserted.
module ctrl_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output id_ctrl_t    id,
  output ex_ctrl_t    ex,
  output mem_ctrl_t   mem,
  output wb_ctrl_t    wb,
  output logic        valid
);

  always_comb begin
    id    = ID_BUBBLE;
    ex    = EX_BUBBLE;
    mem   = MEM_BUBBLE;
    wb    = WB_BUBBLE;
    valid = 1'b1;

    casez (opcode)
      OP_ADD, OP_ADDS: begin
        id.reads_rn  = 1'b1;
        id.reads_rm  = 1'b1;
        ex.alu_op    = ALU_ADD;
        ex.flagset   = (opcode == OP_ADDS);
        wb.reg_write = 1'b1;
      end
      OP_SUB, OP_SUBS: begin
        id.reads_rn  = 1'b1;
        id.reads_rm  = 1'b1;
        ex.alu_op    = ALU_SUB;
        ex.flagset   = (opcode == OP_SUBS);
        wb.reg_write = 1'b1;
      end
      11'b1001000100?: begin // ADDI
        id.reads_rn   = 1'b1;
        ex.alu_src    = 1'b1;
        ex.imm_select = 1'b1;
        ex.alu_op     = ALU_ADD;
        wb.reg_write  = 1'b1;
      end
      OP_LDUR, OP_LDURB: begin
        id.reads_rn    = 1'b1;
        ex.alu_src     = 1'b1;
        ex.alu_op      = ALU_ADD;
        mem.mem_read   = 1'b1;
        mem.xfer_size  = (opcode == OP_LDUR) ? XFER_DWORD : XFER_BYTE;
        wb.reg_write   = 1'b1;
        wb.mem_to_reg  = 1'b1;
      end
      OP_STUR, OP_STURB: begin
        id.reg2loc    = 1'b1;
        id.reads_rn   = 1'b1;
        id.reads_rm   = 1'b1;
        ex.alu_src    = 1'b1;
        ex.alu_op     = ALU_ADD;
        mem.mem_write = 1'b1;
        mem.xfer_size = (opcode == OP_STUR) ? XFER_DWORD : XFER_BYTE;
      end
      11'b000101?????: begin // B
        id.uncond_br    = 1'b1;
        id.uncond_taken = 1'b1;
      end
      11'b100101?????: begin // BL
        id.uncond_br    = 1'b1;
        id.uncond_taken = 1'b1;
        id.blink        = 1'b1;
        wb.reg_write    = 1'b1;
        wb.blink        = 1'b1;
      end
      OP_BR: begin
        id.breg         = 1'b1;
        id.uncond_taken = 1'b1;
        id.reads_rn     = 1'b1;
      end
      11'b10110100???: begin // CBZ
        id.reg2loc  = 1'b1;
        id.is_cbz   = 1'b1;
        id.reads_rm = 1'b1;
        ex.alu_op   = ALU_PASS_B;
      end
      11'b01010100???: begin // B.LT
        id.is_blt = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// LEGv8 5-stage control: ID decode and branch resolution, ID/EX, EX/MEM, MEM/WB
// control registers, NZVC flag register, load-use and flag hazard detection.
module pipelined_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W       = 11,
  parameter int unsigned REG_W       = 5,
  parameter int unsigned XFER_W      = 4,
  parameter bit          FLAG_BYPASS = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  pipelined_control_unit_if.slave bus
);

  localparam logic [REG_W-1:0] XZR = '1;

  logic [OPC_W-1:0] opcode;
  id_ctrl_t         dec_id;
  ex_ctrl_t         dec_ex;
  mem_ctrl_t        dec_mem;
  wb_ctrl_t         dec_wb;
  logic             dec_valid;

  id_ex_t           id_ex_q, id_ex_d;
  ex_mem_t          ex_mem_q, ex_mem_d;
  wb_ctrl_t         mem_wb_q, mem_wb_d;
  logic [3:0]       nzvc_q, nzvc_d;
  logic             illegal_q, illegal_d;

  logic             load_use;
  logic             flag_wait;
  logic             stall;
  logic             blt_n;
  logic             blt_v;
  logic             br_taken;

  assign opcode = bus.opcode_id;

  ctrl_decoder u_decoder (
    .opcode (opcode),
    .id     (dec_id),
    .ex     (dec_ex),
    .mem    (dec_mem),
    .wb     (dec_wb),
    .valid  (dec_valid)
  );

  always_comb begin
    load_use  = id_ex_q.mem.mem_read && (bus.rd_ex != XZR) &&
                ((dec_id.reads_rn && (bus.rd_ex == bus.rn_id)) ||
                 (dec_id.reads_rm && (bus.rd_ex == bus.rm_id)));
    flag_wait = !FLAG_BYPASS && dec_id.is_blt && id_ex_q.ex.flagset;
    stall     = load_use || flag_wait;

    // Flags being written this edge are only visible through the ALU outputs.
    if (FLAG_BYPASS && id_ex_q.ex.flagset) begin
      blt_n = bus.alu_n;
      blt_v = bus.alu_v;
    end else begin
      blt_n = nzvc_q[3];
      blt_v = nzvc_q[1];
    end

    br_taken = !stall &&
               (dec_id.uncond_taken ||
                (dec_id.is_cbz && bus.zero_check) ||
                (dec_id.is_blt && (blt_n ^ blt_v)));

    id_ex_d.ex  = dec_ex;
    id_ex_d.mem = dec_mem;
    id_ex_d.wb  = dec_wb;
    if (stall) begin
      id_ex_d = ID_EX_BUBBLE;
    end

    ex_mem_d.mem = id_ex_q.mem;
    ex_mem_d.wb  = id_ex_q.wb;
    mem_wb_d     = ex_mem_q.wb;

    nzvc_d = id_ex_q.ex.flagset ? {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c}
                                : nzvc_q;
    illegal_d = !dec_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      id_ex_q   <= ID_EX_BUBBLE;
      ex_mem_q  <= EX_MEM_BUBBLE;
      mem_wb_q  <= WB_BUBBLE;
      nzvc_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      id_ex_q   <= id_ex_d;
      ex_mem_q  <= ex_mem_d;
      mem_wb_q  <= mem_wb_d;
      nzvc_q    <= nzvc_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.id_Reg2Loc    = dec_id.reg2loc;
  assign bus.id_UncondBr   = dec_id.uncond_br & ~stall;
  assign bus.id_BrTaken    = br_taken;
  assign bus.id_breg       = dec_id.breg & ~stall;
  assign bus.id_blink      = dec_id.blink & ~stall;
  assign bus.if_flush      = br_taken & ~stall;
  assign bus.hazard_stall  = stall;

  assign bus.ex_ALUSrc     = id_ex_q.ex.alu_src;
  assign bus.ex_imm_select = id_ex_q.ex.imm_select;
  assign bus.ex_flagset    = id_ex_q.ex.flagset;
  assign bus.ex_ALUOp      = id_ex_q.ex.alu_op;

  assign bus.mem_MemWrite  = ex_mem_q.mem.mem_write;
  assign bus.mem_MemRead   = ex_mem_q.mem.mem_read;
  assign bus.mem_xfer_size = XFER_W'(ex_mem_q.mem.xfer_size);

  assign bus.wb_RegWrite   = mem_wb_q.reg_write;
  assign bus.wb_MemToReg   = mem_wb_q.mem_to_reg;
  assign bus.wb_blink      = mem_wb_q.blink;

  assign bus.flags_q       = nzvc_q;
  assign bus.illegal_op    = illegal_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench: drives two control units (flag bypass on / off) with the same
// ID-stage stream and checks hand-computed control values each step.
module tb_pipelined_control_unit;

  localparam logic [10:0] ADD   = 11'b10001011000;
  localparam logic [10:0] SUBS  = 11'b11101011000;
  localparam logic [10:0] ADDI  = 11'b10010001000;
  localparam logic [10:0] LDUR  = 11'b11111000010;
  localparam logic [10:0] STUR  = 11'b11111000000;
  localparam logic [10:0] LDURB = 11'b00111000010;
  localparam logic [10:0] STURB = 11'b00111000000;
  localparam logic [10:0] B_OP  = 11'b00010100011;
  localparam logic [10:0] BL    = 11'b10010111111;
  localparam logic [10:0] BR    = 11'b11010110000;
  localparam logic [10:0] CBZ   = 11'b10110100101;
  localparam logic [10:0] BLT   = 11'b01010100010;
  localparam logic [10:0] ILL   = 11'h7FF;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_control_unit_if #(.OPC_W(11), .REG_W(5), .XFER_W(4)) bus_b ();
  pipelined_control_unit_if #(.OPC_W(11), .REG_W(5), .XFER_W(4)) bus_s ();

  pipelined_control_unit #(.OPC_W(11), .REG_W(5), .XFER_W(4), .FLAG_BYPASS(1'b1)) u_dut_byp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  pipelined_control_unit #(.OPC_W(11), .REG_W(5), .XFER_W(4), .FLAG_BYPASS(1'b0)) u_dut_stl (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  task automatic drive(input logic [10:0] op, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [4:0] rdex, input logic zc, input logic [3:0] nzvc);
    bus_b.opcode_id = op;  bus_s.opcode_id = op;
    bus_b.rn_id = rn;      bus_s.rn_id = rn;
    bus_b.rm_id = rm;      bus_s.rm_id = rm;
    bus_b.rd_ex = rdex;    bus_s.rd_ex = rdex;
    bus_b.zero_check = zc; bus_s.zero_check = zc;
    {bus_b.alu_n, bus_b.alu_z, bus_b.alu_v, bus_b.alu_c} = nzvc;
    {bus_s.alu_n, bus_s.alu_z, bus_s.alu_v, bus_s.alu_c} = nzvc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_b();
    return {5'b0, bus_b.id_Reg2Loc, bus_b.id_UncondBr, bus_b.id_BrTaken, bus_b.id_breg,
            bus_b.id_blink, bus_b.if_flush, bus_b.hazard_stall, bus_b.ex_ALUSrc,
            bus_b.ex_imm_select, bus_b.ex_flagset, bus_b.ex_ALUOp, bus_b.mem_MemWrite,
            bus_b.mem_MemRead, bus_b.mem_xfer_size, bus_b.wb_RegWrite, bus_b.wb_MemToReg,
            bus_b.wb_blink, bus_b.flags_q, bus_b.illegal_op};
  endfunction

  function automatic logic [31:0] pack_s();
    return {5'b0, bus_s.id_Reg2Loc, bus_s.id_UncondBr, bus_s.id_BrTaken, bus_s.id_breg,
            bus_s.id_blink, bus_s.if_flush, bus_s.hazard_stall, bus_s.ex_ALUSrc,
            bus_s.ex_imm_select, bus_s.ex_flagset, bus_s.ex_ALUOp, bus_s.mem_MemWrite,
            bus_s.mem_MemRead, bus_s.mem_xfer_size, bus_s.wb_RegWrite, bus_s.wb_MemToReg,
            bus_s.wb_blink, bus_s.flags_q, bus_s.illegal_op};
  endfunction

  initial begin
    // Reset, then ADD flows through the pipe
    reset = 1'b0;
    drive(ADD, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000);
    tick();
    tick();
    chk("reset_all_byp", pack_b(), 32'h0);
    chk("reset_all_stl", pack_s(), 32'h0);
    reset = 1'b1;
    tick();
    chk("add_ex_aluop", bus_b.ex_ALUOp, 3'b010);
    chk("add_ex_alusrc", bus_b.ex_ALUSrc, 1'b0);
    drive(CBZ, 5'd0, 5'd2, 5'd0, 1'b0, 4'b0000);
    chk("cbz_reg2loc", bus_b.id_Reg2Loc, 1'b1);
    chk("cbz_not_taken", bus_b.id_BrTaken, 1'b0);
    tick();
    chk("cbz_ex_aluop", bus_b.ex_ALUOp, 3'b000);
    chk("add_wb_not_yet", bus_b.wb_RegWrite, 1'b0);
    tick();
    chk("add_wb_regwrite", bus_b.wb_RegWrite, 1'b1);
    chk("add_wb_memtoreg", bus_b.wb_MemToReg, 1'b0);

    // SUBS in EX, B.LT in ID: bypass vs one-cycle flag stall
    drive(SUBS, 5'd1, 5'd2, 5'd5, 1'b0, 4'b0000);
    tick();
    chk("subs_ex_flagset", bus_b.ex_flagset, 1'b1);
    chk("subs_ex_aluop", bus_b.ex_ALUOp, 3'b011);
    drive(BLT, 5'd0, 5'd0, 5'd31, 1'b0, 4'b1000);
    chk("blt_byp_taken", bus_b.id_BrTaken, 1'b1);
    chk("blt_byp_flush", bus_b.if_flush, 1'b1);
    chk("blt_byp_nostall", bus_b.hazard_stall, 1'b0);
    chk("blt_stl_stall", bus_s.hazard_stall, 1'b1);
    chk("blt_stl_taken0", bus_s.id_BrTaken, 1'b0);
    chk("blt_stl_flush0", bus_s.if_flush, 1'b0);
    tick();
    chk("flags_byp_1000", bus_b.flags_q, 4'b1000);
    chk("flags_stl_1000", bus_s.flags_q, 4'b1000);
    drive(BLT, 5'd0, 5'd0, 5'd31, 1'b0, 4'b0000);
    chk("blt_stl_resolved_stall", bus_s.hazard_stall, 1'b0);
    chk("blt_stl_resolved_taken", bus_s.id_BrTaken, 1'b1);
    chk("blt_stl_resolved_flush", bus_s.if_flush, 1'b1);
    chk("blt_byp_flagsq_taken", bus_b.id_BrTaken, 1'b1);
    drive(SUBS, 5'd1, 5'd2, 5'd5, 1'b0, 4'b0000);
    tick();
    drive(BLT, 5'd0, 5'd0, 5'd31, 1'b0, 4'b1011);
    chk("blt_byp_nv_equal", bus_b.id_BrTaken, 1'b0);
    chk("blt_stl_stall2", bus_s.hazard_stall, 1'b1);
    tick();
    chk("flags_byp_1011", bus_b.flags_q, 4'b1011);
    chk("blt_stl_nv_equal_stall", bus_s.hazard_stall, 1'b0);
    chk("blt_stl_nv_equal_taken", bus_s.id_BrTaken, 1'b0);

    // Load-use hazards
    drive(LDUR, 5'd0, 5'd0, 5'd31, 1'b0, 4'b0000);
    tick();
    drive(ADD, 5'd1, 5'd2, 5'd1, 1'b0, 4'b0000);
    chk("lu_rn_stall", bus_b.hazard_stall, 1'b1);
    chk("lu_rn_flush", bus_b.if_flush, 1'b0);
    tick();
    chk("lu_bubble_aluop", bus_b.ex_ALUOp, 3'b000);
    chk("lu_bubble_alusrc", bus_b.ex_ALUSrc, 1'b0);
    chk("lu_ldur_memread", bus_b.mem_MemRead, 1'b1);
    chk("lu_ldur_xfer", bus_b.mem_xfer_size, 4'd8);
    chk("lu_released", bus_b.hazard_stall, 1'b0);
    tick();
    chk("lu_add_ex", bus_b.ex_ALUOp, 3'b010);
    drive(LDUR, 5'd0, 5'd0, 5'd31, 1'b0, 4'b0000);
    tick();
    drive(STUR, 5'd4, 5'd3, 5'd3, 1'b0, 4'b0000);
    chk("lu_rm_stall", bus_b.hazard_stall, 1'b1);
    tick();
    drive(LDUR, 5'd0, 5'd0, 5'd31, 1'b0, 4'b0000);
    tick();
    drive(ADD, 5'd31, 5'd31, 5'd31, 1'b0, 4'b0000);
    chk("lu_xzr_nostall", bus_b.hazard_stall, 1'b0);
    tick();
    chk("lu_xzr_add_ex", bus_b.ex_ALUOp, 3'b010);

    // Byte and doubleword transfers
    drive(LDURB, 5'd0, 5'd0, 5'd31, 1'b0, 4'b0000);
    tick();
    drive(STURB, 5'd2, 5'd3, 5'd31, 1'b0, 4'b0000);
    chk("sturb_reg2loc", bus_b.id_Reg2Loc, 1'b1);
    chk("sturb_nostall", bus_b.hazard_stall, 1'b0);
    tick();
    chk("ldurb_mem", {bus_b.mem_MemWrite, bus_b.mem_MemRead, bus_b.mem_xfer_size}, 6'b01_0001);
    drive(LDUR, 5'd0, 5'd0, 5'd31, 1'b0, 4'b0000);
    tick();
    chk("sturb_mem", {bus_b.mem_MemWrite, bus_b.mem_MemRead, bus_b.mem_xfer_size}, 6'b10_0001);
    chk("ldurb_wb", {bus_b.wb_RegWrite, bus_b.wb_MemToReg, bus_b.wb_blink}, 3'b110);
    drive(CBZ, 5'd0, 5'd0, 5'd31, 1'b0, 4'b0000);
    tick();
    chk("ldur_mem", {bus_b.mem_MemWrite, bus_b.mem_MemRead, bus_b.mem_xfer_size}, 6'b01_1000);

    // Illegal opcode, BL, ADDI, CBZ taken, BR, B
    drive(ILL, 5'd0, 5'd0, 5'd31, 1'b0, 4'b0000);
    chk("ill_id_quiet", pack_b() & 32'h07F0_0000, 32'h0);
    tick();
    chk("ill_pulse", bus_b.illegal_op, 1'b1);
    chk("ill_ex_bubble", {bus_b.ex_ALUSrc, bus_b.ex_imm_select, bus_b.ex_flagset, bus_b.ex_ALUOp}, 6'b0);
    drive(BL, 5'd0, 5'd0, 5'd31, 1'b0, 4'b0000);
    chk("bl_id", {bus_b.id_UncondBr, bus_b.id_BrTaken, bus_b.id_breg, bus_b.id_blink, bus_b.if_flush}, 5'b11011);
    tick();
    chk("ill_pulse_end", bus_b.illegal_op, 1'b0);
    drive(ADDI, 5'd2, 5'd0, 5'd31, 1'b0, 4'b0000);
    tick();
    chk("addi_ex", {bus_b.ex_ALUSrc, bus_b.ex_imm_select, bus_b.ex_flagset, bus_b.ex_ALUOp}, 6'b110_010);
    drive(CBZ, 5'd0, 5'd0, 5'd31, 1'b1, 4'b0000);
    chk("cbz_taken", {bus_b.id_UncondBr, bus_b.id_BrTaken, bus_b.if_flush}, 3'b011);
    tick();
    chk("bl_wb", {bus_b.wb_RegWrite, bus_b.wb_MemToReg, bus_b.wb_blink}, 3'b101);
    drive(BR, 5'd5, 5'd0, 5'd31, 1'b0, 4'b0000);
    chk("br_id", {bus_b.id_UncondBr, bus_b.id_BrTaken, bus_b.id_breg, bus_b.id_blink}, 4'b0110);
    drive(B_OP, 5'd0, 5'd0, 5'd31, 1'b0, 4'b0000);
    chk("b_id", {bus_b.id_UncondBr, bus_b.id_BrTaken, bus_b.id_breg, bus_b.id_blink}, 4'b1100);

    // Reset with flag-setting instructions in flight
    drive(SUBS, 5'd1, 5'd2, 5'd31, 1'b0, 4'b0000);
    tick();
    tick();
    chk("pre_reset_flagset", bus_b.ex_flagset, 1'b1);
    chk("pre_reset_flags0", bus_b.flags_q, 4'b0000);
    reset = 1'b0;
    drive(SUBS, 5'd1, 5'd2, 5'd31, 1'b0, 4'b1111);
    tick();
    chk("midreset_all_byp", pack_b(), 32'h0);
    chk("midreset_all_stl", pack_s(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
